// File: rtl/adder_mask_pkg.sv
// Shared types and width helpers for the adder routing-mask generator.
package adder_mask_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int bit_out_ch(input int out_ch);
    return (out_ch > 1) ? $clog2(out_ch) : 1;
  endfunction

  // Width of a count that must be able to hold the value n itself.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_mask_row.sv
// One mask row: compares macro row_i's filter index against every macro and
// flags row_i as leader when no lower-indexed enabled macro shares its filter.
module adder_mask_row
  import adder_mask_pkg::*;
#(
  parameter int NUM_MACRO  = 16,
  parameter int BIT_OUT_CH = 9,
  localparam int IDX_W     = idx_w(NUM_MACRO)
) (
  input  logic [IDX_W-1:0]                      row_i,
  input  logic [NUM_MACRO-1:0][BIT_OUT_CH-1:0]  wf_i,
  input  logic [NUM_MACRO-1:0]                  en_i,
  output logic [NUM_MACRO-1:0]                  eq_o,
  output logic                                  leader_o
);

  logic [NUM_MACRO-1:0] below;

  always_comb begin
    for (int j = 0; j < NUM_MACRO; j++) begin
      eq_o[j]  = en_i[row_i] & en_i[j] & (wf_i[j] == wf_i[row_i]);
      below[j] = (j < int'(row_i));
    end
    leader_o = en_i[row_i] & ~|(eq_o & below);
  end

endmodule

// File: rtl/adder_mask_gen.sv
// Macro-to-adder routing mask generator, ROWS_PER_CYCLE rows per CALC cycle.
// Define ADDER_MASK_LEADER_EN to gate each row by its leader bit.
module adder_mask_gen
  import adder_mask_pkg::*;
#(
  parameter int NUM_MACRO      = 16,
  parameter int OUT_CH         = 512,
  parameter int ROWS_PER_CYCLE = 4,
  localparam int BIT_OUT_CH    = bit_out_ch(OUT_CH),
  localparam int CNT_W         = cnt_w(NUM_MACRO)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_MACRO*BIT_OUT_CH-1:0] WHICH_FILTER,
  input  logic [NUM_MACRO-1:0]            MACRO_EN,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_MACRO*NUM_MACRO-1:0]  Adder_mask,
  output logic [NUM_MACRO-1:0]            leader,
  output logic [CNT_W-1:0]                group_cnt
);

  localparam int RPC = ROWS_PER_CYCLE;
  localparam int IDX_W = idx_w(NUM_MACRO);
  localparam logic [IDX_W-1:0] LAST_R = IDX_W'(NUM_MACRO - RPC);
  localparam logic [IDX_W-1:0] STEP   = IDX_W'(RPC);

  state_e                                state_q, state_d;
  logic [NUM_MACRO-1:0][BIT_OUT_CH-1:0]  wf_q, wf_d;
  logic [NUM_MACRO-1:0]                  en_q, en_d;
  logic [NUM_MACRO-1:0][NUM_MACRO-1:0]   mask_q, mask_d;
  logic [NUM_MACRO-1:0]                  leader_q, leader_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic [IDX_W-1:0]                      r_q, r_d;

  logic [RPC-1:0][IDX_W-1:0]             row_idx;
  logic [RPC-1:0][NUM_MACRO-1:0]         row_eq;
  logic [RPC-1:0]                        row_lead;

  for (genvar k = 0; k < RPC; k++) begin : g_row
    assign row_idx[k] = r_q + IDX_W'(k);
    adder_mask_row #(
      .NUM_MACRO (NUM_MACRO),
      .BIT_OUT_CH(BIT_OUT_CH)
    ) u_row (
      .row_i   (row_idx[k]),
      .wf_i    (wf_q),
      .en_i    (en_q),
      .eq_o    (row_eq[k]),
      .leader_o(row_lead[k])
    );
  end

  always_comb begin
    state_d  = state_q;
    wf_d     = wf_q;
    en_d     = en_q;
    mask_d   = mask_q;
    leader_d = leader_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        wf_d     = WHICH_FILTER;
        en_d     = MACRO_EN;
        mask_d   = '0;
        leader_d = '0;
        cnt_d    = '0;
        r_d      = '0;
        state_d  = ST_CALC;
      end
      ST_CALC: begin
        for (int k = 0; k < RPC; k++) begin
`ifdef ADDER_MASK_LEADER_EN
          mask_d[row_idx[k]] = row_eq[k] & {NUM_MACRO{row_lead[k]}};
`else
          mask_d[row_idx[k]] = row_eq[k];
`endif
          leader_d[row_idx[k]] = row_lead[k];
          cnt_d = cnt_d + CNT_W'(row_lead[k]);
        end
        r_d = r_q + STEP;
        if (r_q == LAST_R) state_d = ST_DONE;
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wf_q     <= '0;
      en_q     <= '0;
      mask_q   <= '0;
      leader_q <= '0;
      cnt_q    <= '0;
      r_q      <= '0;
    end else begin
      state_q  <= state_d;
      wf_q     <= wf_d;
      en_q     <= en_d;
      mask_q   <= mask_d;
      leader_q <= leader_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign Adder_mask = mask_q;
  assign leader     = leader_q;
  assign group_cnt  = cnt_q;

endmodule

// File: tb/tb_adder_mask_gen.sv
// Randomized and directed bench for adder_mask_gen against a set-based model.
module tb_adder_mask_gen;
  localparam int N  = 16;
  localparam int OC = 512;
  localparam int RPC = 4;
  localparam int BW = 9;
  localparam int CW = 5;
  localparam int K  = N / RPC;
`ifdef ADDER_MASK_LEADER_EN
  localparam bit GATED = 1'b1;
`else
  localparam bit GATED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [N*BW-1:0] WHICH_FILTER;
  logic [N-1:0]    MACRO_EN, leader;
  logic [N*N-1:0]  Adder_mask;
  logic [CW-1:0]   group_cnt;

  adder_mask_gen #(.NUM_MACRO(N), .OUT_CH(OC), .ROWS_PER_CYCLE(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .WHICH_FILTER(WHICH_FILTER), .MACRO_EN(MACRO_EN), .out_valid(out_valid),
    .out_ready(out_ready), .Adder_mask(Adder_mask), .leader(leader), .group_cnt(group_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [N*N-1:0] exp_mask, got_mask;
  logic [N-1:0]   exp_leader, got_leader;
  int             exp_cnt;
  logic [CW-1:0]  got_cnt;
  bit             chk_en = 1'b0;

  task automatic check(input string name, input logic [N*N-1:0] act, input logic [N*N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Groups = sets of enabled macros sharing a filter index; the leader is the
  // lowest member, and the count is the number of distinct indices in use.
  task automatic model(input logic [N*BW-1:0] wf, input logic [N-1:0] en);
    int v[N];
    int seen[$];
    int first;
    for (int m = 0; m < N; m++) v[m] = int'(wf[m*BW +: BW]);
    exp_mask = '0;
    exp_leader = '0;
    seen.delete();
    for (int j = 0; j < N; j++) begin
      if (!en[j]) continue;
      first = -1;
      for (int i = 0; i < N; i++)
        if (first < 0 && en[i] && v[i] == v[j]) first = i;
      exp_leader[first] = 1'b1;
      if (!(v[j] inside {seen})) seen.push_back(v[j]);
      if (GATED) exp_mask[first*N + j] = 1'b1;
      else
        for (int i = 0; i < N; i++)
          if (en[i] && v[i] == v[j]) exp_mask[i*N + j] = 1'b1;
    end
    exp_cnt = seen.size();
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n && out_valid) begin
      check("mask", Adder_mask, exp_mask);
      check("leader", leader, exp_leader);
      check("group_cnt", group_cnt, exp_cnt);
      check("in_ready_in_done", in_ready, 1'b0);
    end
  end

  task automatic run_job(input logic [N*BW-1:0] wf, input logic [N-1:0] en, input int stall);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1'b1);
    check("out_valid_idle", out_valid, 1'b0);
    model(wf, en);
    chk_en = 1'b1;
    WHICH_FILTER = wf;
    MACRO_EN = en;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'($urandom);
    WHICH_FILTER = {$urandom, $urandom, $urandom, $urandom, $urandom};
    MACRO_EN = N'($urandom);
    check("in_ready_busy", in_ready, 1'b0);
    for (int c = 0; c < K; c++) begin
      check("out_valid_early", out_valid, 1'b0);
      @(negedge clk);
    end
    check("out_valid_latency", out_valid, 1'b1);
    got_mask = Adder_mask;
    got_leader = leader;
    got_cnt = group_cnt;
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      WHICH_FILTER = {$urandom, $urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check("out_valid_stall", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("out_valid_release", out_valid, 1'b0);
    check("in_ready_release", in_ready, 1'b1);
    out_ready = 1'($urandom);
  endtask

  function automatic logic [N*BW-1:0] pack4(input int a, b, c, d);
    logic [N*BW-1:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom};
    w[0*BW +: BW] = BW'(a);
    w[1*BW +: BW] = BW'(b);
    w[2*BW +: BW] = BW'(c);
    w[3*BW +: BW] = BW'(d);
    return w;
  endfunction

  task automatic check_lit(input string tag, input logic [15:0] r0, r1, r2, r3,
                           input logic [15:0] ld, input int cnt);
    check({tag, "_row0"}, got_mask[0*N +: N], r0);
    check({tag, "_row1"}, got_mask[1*N +: N], r1);
    check({tag, "_row2"}, got_mask[2*N +: N], r2);
    check({tag, "_row3"}, got_mask[3*N +: N], r3);
    check({tag, "_rows_hi"}, got_mask[N*N-1:4*N], '0);
    check({tag, "_leader"}, got_leader, ld);
    check({tag, "_cnt"}, got_cnt, cnt);
  endtask

  initial begin
    logic [N*BW-1:0] wf;
    logic [N-1:0] en;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    WHICH_FILTER = '0; MACRO_EN = '0;
    #3 rst_n = 1'b0;
    #3;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_mask", Adder_mask, '0);
    check("rst_leader", leader, '0);
    check("rst_cnt", group_cnt, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_job(pack4(3, 2, 1, 0), 16'h000F, 0);
    check_lit("distinct", 16'h1, 16'h2, 16'h4, 16'h8, 16'h000F, 4);

    run_job(pack4(7, 7, 7, 7), 16'h000F, 1);
    if (GATED) check_lit("same", 16'hF, 16'h0, 16'h0, 16'h0, 16'h0001, 1);
    else       check_lit("same", 16'hF, 16'hF, 16'hF, 16'hF, 16'h0001, 1);

    run_job(pack4(5, 9, 5, 9), 16'h000D, 5);
    if (GATED) check_lit("pairs", 16'h5, 16'h0, 16'h0, 16'h8, 16'h0009, 2);
    else       check_lit("pairs", 16'h5, 16'h0, 16'h5, 16'h8, 16'h0009, 2);

    // Reset asserted in the second CALC cycle, then a clean job.
    @(negedge clk);
    WHICH_FILTER = pack4(1, 1, 2, 2);
    MACRO_EN = '1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_mask", Adder_mask, '0);
    check("midrst_leader", leader, '0);
    check("midrst_cnt", group_cnt, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < K + 1; c++) begin
      @(negedge clk);
      check("postrst_out_valid", out_valid, 1'b0);
    end
    run_job(pack4(5, 9, 5, 9), 16'h000D, 0);
    if (GATED) check_lit("after_rst", 16'h5, 16'h0, 16'h0, 16'h8, 16'h0009, 2);
    else       check_lit("after_rst", 16'h5, 16'h0, 16'h5, 16'h8, 16'h0009, 2);

    for (int t = 0; t < 100; t++) begin
      for (int m = 0; m < N; m++)
        wf[m*BW +: BW] = (t % 3 == 0) ? BW'($urandom % 511) : BW'($urandom % 4);
      en = ($urandom % 4 == 0) ? '1 : N'($urandom);
      run_job(wf, en, int'($urandom % 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
